// File: rtl/fb_rasterizer.sv
// Rasterises plot / fill-rectangle / clear commands into one framebuffer pixel write per cycle.
// Define FB_RASTERIZER_CLIP_EN to clip rectangles to the FB_WIDTH x FB_HEIGHT framebuffer.
module fb_rasterizer #(
  parameter int FB_WIDTH  = 214,
  parameter int FB_HEIGHT = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_x0,
  input  logic [7:0]  cmd_y0,
  input  logic [7:0]  cmd_x1,
  input  logic [7:0]  cmd_y1,
  input  logic [2:0]  cmd_color,
  output logic [15:0] fb_write_addr,
  output logic [2:0]  fb_write_data,
  output logic        fb_write_en,
  output logic        busy
);
  localparam logic [15:0] W16  = 16'(FB_WIDTH);
  localparam logic [7:0]  XMAX = 8'(FB_WIDTH - 1);
  localparam logic [7:0]  YMAX = 8'(FB_HEIGHT - 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t      state_q;
  logic [7:0]  x_q, y_q, x0_q, x1_q, y1_q;
  logic [15:0] row_q, addr_q;
  logic [2:0]  data_q;
  logic        en_q;

  logic [7:0]  x0_d, y0_d, x1_d, y1_d;
  logic [15:0] row_d;
  logic        empty_d;

  // Every op is reduced to an inclusive rectangle plus an empty flag.
  always_comb begin
    x0_d = cmd_x0;
    y0_d = cmd_y0;
    x1_d = cmd_x1;
    y1_d = cmd_y1;
    case (cmd_op)
      2'b00: begin
        x1_d = cmd_x0;
        y1_d = cmd_y0;
      end
      2'b10: begin
        x0_d = '0;
        y0_d = '0;
        x1_d = XMAX;
        y1_d = YMAX;
      end
      default: ;
    endcase
`ifdef FB_RASTERIZER_CLIP_EN
    // After clamping, an off-screen x0/y0 shows up as x0>x1 / y0>y1.
    if (x1_d > XMAX) x1_d = XMAX;
    if (y1_d > YMAX) y1_d = YMAX;
`endif
    empty_d = (cmd_op == 2'b11) || (x0_d > x1_d) || (y0_d > y1_d);
    row_d   = 16'(y0_d) * W16;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q <= DRAW;
            x_q     <= x0_d;
            y_q     <= y0_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            row_q   <= row_d;
            en_q    <= !empty_d;
            if (!empty_d) begin
              addr_q <= row_d + 16'(x0_d);
              data_q <= cmd_color;
            end
          end
        end
        DRAW: begin
          // The registered outputs already carry the pixel at (x_q, y_q).
          if (!en_q || (x_q == x1_q && y_q == y1_q)) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
          end else if (x_q == x1_q) begin
            x_q    <= x0_q;
            y_q    <= y_q + 8'd1;
            row_q  <= row_q + W16;
            addr_q <= row_q + W16 + 16'(x0_q);
          end else begin
            x_q    <= x_q + 8'd1;
            addr_q <= addr_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q == DRAW);
  assign fb_write_en   = en_q;
  assign fb_write_addr = addr_q;
  assign fb_write_data = data_q;
endmodule

// File: tb/tb_fb_rasterizer.sv
// Self-checking bench for fb_rasterizer: directed and random commands against a rectangle-list model.
module tb_fb_rasterizer;
  localparam int W = 214;
  localparam int H = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [7:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [2:0]  cmd_color = '0;
  logic [15:0] fb_write_addr;
  logic [2:0]  fb_write_data;
  logic        fb_write_en;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  logic [2:0] exp_color;

  always #5 clk = ~clk;

  fb_rasterizer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
    .fb_write_en(fb_write_en), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the list of pixel addresses a command must produce, in row-major order.
  task automatic model(input int op, input int x0, input int y0, input int x1, input int y1);
    int ax0, ay0, ax1, ay1;
    bit emp;
    ax0 = x0; ay0 = y0; ax1 = x1; ay1 = y1;
    emp = (op == 3);
    if (op == 0) begin ax1 = x0; ay1 = y0; end
    if (op == 2) begin ax0 = 0; ay0 = 0; ax1 = W - 1; ay1 = H - 1; end
`ifdef FB_RASTERIZER_CLIP_EN
    if (ax1 > W - 1) ax1 = W - 1;
    if (ay1 > H - 1) ay1 = H - 1;
    if (ax0 >= W || ay0 >= H) emp = 1'b1;
`endif
    exp_q.delete();
    if (!emp)
      for (int y = ay0; y <= ay1; y++)
        for (int x = ax0; x <= ax1; x++)
          exp_q.push_back((y * W + x) % 65536);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] x0, input logic [7:0] y0,
                       input logic [7:0] x1, input logic [7:0] y1, input logic [2:0] c);
    model(int'(op), int'(x0), int'(y0), int'(x1), int'(y1));
    exp_color = c;
    @(negedge clk);
    check("ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = c;
    @(posedge clk); #1;
    // Garbage on the command bus must not disturb the command in progress.
    cmd_valid = 1'b0; cmd_op = 2'($urandom);
    cmd_x0 = 8'($urandom); cmd_y0 = 8'($urandom); cmd_x1 = 8'($urandom); cmd_y1 = 8'($urandom);
    cmd_color = 3'($urandom);
  endtask

  task automatic drain(input string tag);
    int cyc, idx, exp_busy;
    logic [31:0] exp_a;
    cyc = 0; idx = 0;
    while (cmd_ready !== 1'b1 && cyc < 40000) begin
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      if (fb_write_en === 1'b1) begin
        exp_a = (idx < exp_q.size()) ? 32'(exp_q[idx]) : 32'hFFFF_FFFF;
        check({tag, "_addr"}, {16'b0, fb_write_addr}, exp_a);
        check({tag, "_data"}, {29'b0, fb_write_data}, {29'b0, exp_color});
        check({tag, "_nogap"}, 32'(idx), 32'(cyc));
        idx++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    exp_busy = (exp_q.size() == 0) ? 1 : exp_q.size();
    check({tag, "_nwrites"}, 32'(idx), 32'(exp_q.size()));
    check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_busy));
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [7:0] x0, input logic [7:0] y0,
                     input logic [7:0] x1, input logic [7:0] y1, input logic [2:0] c);
    issue(op, x0, y0, x1, y1, c);
    drain(tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, {31'b0, cmd_ready}, 32'd1);
    check({tag, "_busy"},  {31'b0, busy}, 32'd0);
    check({tag, "_en"},    {31'b0, fb_write_en}, 32'd0);
    check({tag, "_addr"},  {16'b0, fb_write_addr}, 32'd0);
    check({tag, "_data"},  {29'b0, fb_write_data}, 32'd0);
  endtask

  initial begin
    int op, x0, y0, x1, y1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    run("plot_3_2", 2'b00, 8'd3, 8'd2, 8'd99, 8'd99, 3'd5);
    run("fill_10_1", 2'b01, 8'd10, 8'd1, 8'd11, 8'd2, 3'd3);
    run("fill_empty", 2'b01, 8'd5, 8'd0, 8'd4, 8'd0, 3'd6);
    run("op_reserved", 2'b11, 8'd1, 8'd1, 8'd4, 8'd4, 3'd2);
    run("fill_offscreen", 2'b01, 8'd212, 8'd159, 8'd215, 8'd161, 3'd7);
`ifdef FB_RASTERIZER_CLIP_EN
    run("clip_corner", 2'b01, 8'd212, 8'd159, 8'd250, 8'd200, 3'd7);
    run("clip_empty", 2'b01, 8'd220, 8'd0, 8'd230, 8'd5, 3'd1);
`endif
    run("clear", 2'b10, 8'd7, 8'd7, 8'd1, 8'd1, 3'd0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      if (op == 2) op = 3;
      x0 = $urandom_range(0, 240);
      y0 = $urandom_range(0, 200);
      x1 = x0 + $urandom_range(0, 8) - 2;
      y1 = y0 + $urandom_range(0, 5) - 2;
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      if (x1 > 255) x1 = 255;
      if (y1 > 255) y1 = 255;
      run("random", 2'(op), 8'(x0), 8'(y0), 8'(x1), 8'(y1), 3'($urandom));
    end

    // Reset in the middle of a clear aborts it for good.
    issue(2'b10, 8'd0, 8'd0, 8'd0, 8'd0, 3'd4);
    repeat (100) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("abort");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("abort_no_write", {31'b0, fb_write_en}, 32'd0);
    end
    check("abort_ready", {31'b0, cmd_ready}, 32'd1);
    run("plot_after_abort", 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 3'd2);

    // Reset wins over a simultaneous handshake.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_x0 = 8'd9; cmd_y0 = 8'd9; cmd_color = 3'd7; rst = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; rst = 1'b0;
    check_reset_state("rst_vs_cmd");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_vs_cmd_no_write", {31'b0, fb_write_en}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
